// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch and micro-cycle sequencer. Fetches 32-bit instructions
//   over a strobe/acknowledge bus into the instruction register, owns the
//   micro-cycle register consumed by decode, retires instructions (PC += 4)
//   and redirects to TRAP_PC when decode flags an undefined instruction.
//
// Ports
//   clk_i, reset_i   core clock; asynchronous active-high reset
//   iadr_o, istb_o   fetch address (current PC) and fetch request
//   iack_i, idat_i   bus acknowledge and instruction word (same cycle)
//   ir_o             instruction register, to decode
//   cstate_o         current micro-cycle, to decode
//   nstate_i         next micro-cycle, from decode
//   defined_i        instruction-defined flag, from decode
//   pc_o             address of the instruction held in ir_o
//   retire_o         one-cycle pulse per retired instruction
//   trap_o           one-cycle pulse per undefined-instruction trap
//   epc_o            PC of the last trapping instruction
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0100,
    parameter logic [63:0] TRAP_PC  = 64'h0000_0000_0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [63:0] iadr_o,
    output logic        istb_o,
    input  logic        iack_i,
    input  logic [31:0] idat_i,
    output logic [31:0] ir_o,
    output logic [2:0]  cstate_o,
    input  logic [2:0]  nstate_i,
    input  logic        defined_i,
    output logic [63:0] pc_o,
    output logic        retire_o,
    output logic        trap_o,
    output logic [63:0] epc_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } phase_t;

    // Micro-cycle value meaning "instruction complete / not executing".
    localparam logic [2:0] CS_DONE = 3'd3;

    phase_t      phase_q, phase_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [2:0]  cstate_q, cstate_d;
    logic        istb_q, istb_d;
    logic        retire_q, retire_d;
    logic        trap_q, trap_d;
    logic [63:0] epc_q, epc_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            cstate_q <= CS_DONE;
            istb_q   <= 1'b0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            epc_q    <= 64'd0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cstate_q <= cstate_d;
            istb_q   <= istb_d;
            retire_q <= retire_d;
            trap_q   <= trap_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cstate_d = cstate_q;
        istb_d   = istb_q;
        epc_d    = epc_q;
        // Pulses last exactly one cycle unless re-raised below.
        retire_d = 1'b0;
        trap_d   = 1'b0;

        case (phase_q)
            IDLE: begin
                phase_d = FETCH;
                istb_d  = 1'b1;
            end
            FETCH: begin
                // Without an ack everything holds, so the strobe and
                // address stay stable across wait states.
                if (iack_i) begin
                    ir_d     = idat_i;
                    cstate_d = 3'd0;
                    istb_d   = 1'b0;
                    phase_d  = EXEC;
                end
            end
            EXEC: begin
                // Trap takes priority; it is only meaningful in the first
                // micro-cycle, where decode judges the fresh instruction.
                if (cstate_q == 3'd0 && !defined_i) begin
                    epc_d    = pc_q;
                    pc_d     = TRAP_PC;
                    trap_d   = 1'b1;
                    cstate_d = CS_DONE;
                    istb_d   = 1'b1;
                    phase_d  = FETCH;
                end else if (cstate_q == CS_DONE) begin
                    pc_d     = pc_q + 64'd4;
                    retire_d = 1'b1;
                    istb_d   = 1'b1;
                    phase_d  = FETCH;
                end else begin
                    cstate_d = nstate_i;
                end
            end
            default: begin
                phase_d = IDLE;
                istb_d  = 1'b0;
            end
        endcase
    end

    assign iadr_o   = pc_q;
    assign pc_o     = pc_q;
    assign istb_o   = istb_q;
    assign ir_o     = ir_q;
    assign cstate_o = cstate_q;
    assign retire_o = retire_q;
    assign trap_o   = trap_q;
    assign epc_o    = epc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [63:0] TRAP = 64'h0;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] iadr_o, pc_o, epc_o;
    logic        istb_o, iack_i, defined_i, retire_o, trap_o;
    logic [31:0] idat_i, ir_o;
    logic [2:0]  cstate_o, nstate_i;

    // second instance exercises PC wrap
    logic [63:0] iadr2, pc2, epc2;
    logic        istb2, iack2, retire2, trap2;
    logic [31:0] ir2;
    logic [2:0]  cstate2;
    logic [2:0]  nstate2 = 3'd3;
    logic        defined2 = 1'b1;
    logic [31:0] idat2 = 32'h0000_0013;

    int checks = 0;
    int errors = 0;
    int cur_len = 3;

    // reference state
    logic [63:0] m_pc, m_epc;
    logic [31:0] m_ir;

    always #5 clk_i = ~clk_i;

    fetch_sequencer dut (
        .clk_i(clk_i), .reset_i(reset_i), .iadr_o(iadr_o), .istb_o(istb_o),
        .iack_i(iack_i), .idat_i(idat_i), .ir_o(ir_o), .cstate_o(cstate_o),
        .nstate_i(nstate_i), .defined_i(defined_i), .pc_o(pc_o),
        .retire_o(retire_o), .trap_o(trap_o), .epc_o(epc_o)
    );

    fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk_i(clk_i), .reset_i(reset_i), .iadr_o(iadr2), .istb_o(istb2),
        .iack_i(iack2), .idat_i(idat2), .ir_o(ir2), .cstate_o(cstate2),
        .nstate_i(nstate2), .defined_i(defined2), .pc_o(pc2),
        .retire_o(retire2), .trap_o(trap2), .epc_o(epc2)
    );

    // decode model: an instruction of length L walks 0,1,..,L-1 then 3
    always_comb begin
        if (int'(cstate_o) + 1 >= cur_len) nstate_i = 3'd3;
        else                               nstate_i = cstate_o + 3'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one instruction starting at a negedge inside a FETCH cycle and
    // ends at the negedge where the retire/trap pulse is visible.
    task automatic do_instr(input logic [31:0] dat, input bit def, input int wt,
                            input int len, input bit spur, input logic [63:0] exp_adr,
                            input logic [63:0] exp_next, input logic [63:0] exp_epc);
        for (int i = 0; i <= wt; i++) begin
            chk("fetch_stb", {63'd0, istb_o}, 64'd1);
            chk("fetch_adr", iadr_o, exp_adr);
            chk("pc_eq_adr", pc_o, exp_adr);
            chk("ir_hold", {32'd0, ir_o}, {32'd0, m_ir});
            chk("fetch_cstate", {61'd0, cstate_o}, 64'd3);
            iack_i    = (i == wt);
            idat_i    = (i == wt) ? dat : $urandom;
            defined_i = def;
            cur_len   = len;
            @(negedge clk_i);
        end
        iack_i = 1'b0;
        idat_i = $urandom;
        m_ir   = dat;
        chk("ir_load", {32'd0, ir_o}, {32'd0, dat});
        chk("cs0", {61'd0, cstate_o}, 64'd0);
        chk("stb_drop", {63'd0, istb_o}, 64'd0);
        chk("pulse_clr", {62'd0, retire_o, trap_o}, 64'd0);
        if (!def) begin
            @(negedge clk_i);
            chk("trap_pulse", {63'd0, trap_o}, 64'd1);
            chk("trap_noretire", {63'd0, retire_o}, 64'd0);
            chk("trap_stb", {63'd0, istb_o}, 64'd1);
            chk("trap_adr", iadr_o, exp_next);
            chk("trap_epc", epc_o, exp_epc);
            chk("trap_cs", {61'd0, cstate_o}, 64'd3);
        end else begin
            for (int k = 1; k <= len; k++) begin
                @(negedge clk_i);
                iack_i = 1'b0;
                chk("exec_cs", {61'd0, cstate_o}, (k < len) ? k : 3);
                chk("exec_nopulse", {62'd0, retire_o, trap_o}, 64'd0);
                chk("exec_stb", {63'd0, istb_o}, 64'd0);
                chk("exec_ir", {32'd0, ir_o}, {32'd0, dat});
                chk("exec_adr", iadr_o, exp_adr);
                chk("exec_epc", epc_o, exp_epc);
                if (spur && k == 1) begin
                    iack_i = 1'b1;
                    idat_i = 32'hFFFF_FFFF;
                end
            end
            @(negedge clk_i);
            iack_i = 1'b0;
            chk("retire_pulse", {63'd0, retire_o}, 64'd1);
            chk("retire_notrap", {63'd0, trap_o}, 64'd0);
            chk("retire_stb", {63'd0, istb_o}, 64'd1);
            chk("retire_adr", iadr_o, exp_next);
            chk("retire_cs", {61'd0, cstate_o}, 64'd3);
            chk("retire_ir", {32'd0, ir_o}, {32'd0, dat});
        end
    endtask

    // async reset between edges: immediate effect, no pulses afterwards
    task automatic async_reset(input string tag);
        #2 reset_i = 1'b1;
        #1;
        chk({tag, "_stb"}, {63'd0, istb_o}, 64'd0);
        chk({tag, "_cs"}, {61'd0, cstate_o}, 64'd3);
        chk({tag, "_pc"}, pc_o, 64'h100);
        chk({tag, "_pulse"}, {62'd0, retire_o, trap_o}, 64'd0);
        @(negedge clk_i);
        chk({tag, "_hold_pulse"}, {62'd0, retire_o, trap_o}, 64'd0);
        reset_i = 1'b0;
        iack_i  = 1'b0;
        m_ir    = 32'd0;
        @(negedge clk_i);
        chk({tag, "_refetch_stb"}, {63'd0, istb_o}, 64'd1);
        chk({tag, "_refetch_adr"}, iadr_o, 64'h100);
        chk({tag, "_refetch_pulse"}, {62'd0, retire_o, trap_o}, 64'd0);
    endtask

    typedef struct {
        logic [31:0] dat;
        bit          def;
        int          wt;
        int          len;
        bit          spur;
        logic [63:0] exp_adr;
        logic [63:0] exp_next;
        logic [63:0] exp_epc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0420_0093, 1'b1, 0, 3, 1'b0, 64'h100, 64'h104, 64'h0};
        vecs[1] = '{32'h0420_0093, 1'b1, 3, 3, 1'b0, 64'h104, 64'h108, 64'h0};
        vecs[2] = '{32'h0000_0000, 1'b0, 0, 3, 1'b0, 64'h108, TRAP,    64'h108};
        vecs[3] = '{32'h0050_0113, 1'b1, 1, 3, 1'b1, 64'h000, 64'h004, 64'h108};
        vecs[4] = '{32'h0000_0013, 1'b1, 2, 1, 1'b0, 64'h004, 64'h008, 64'h108};

        reset_i = 1'b1; iack_i = 1'b0; idat_i = 32'd0; defined_i = 1'b1; iack2 = 1'b0;
        m_ir = 32'd0;
        #3;
        chk("rst_stb", {63'd0, istb_o}, 64'd0);
        chk("rst_adr", iadr_o, 64'h100);
        chk("rst_cs", {61'd0, cstate_o}, 64'd3);
        chk("rst_ir", {32'd0, ir_o}, 64'd0);
        chk("rst_pulse", {62'd0, retire_o, trap_o}, 64'd0);
        chk("rst_epc", epc_o, 64'd0);
        // ack concurrent with reset must not load ir
        iack_i = 1'b1; idat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("rst_ack_ir", {32'd0, ir_o}, 64'd0);
        iack_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("edge0_stb", {63'd0, istb_o}, 64'd1);
        chk("edge0_adr", iadr_o, 64'h100);

        for (int v = 0; v < 5; v++)
            do_instr(vecs[v].dat, vecs[v].def, vecs[v].wt, vecs[v].len, vecs[v].spur,
                     vecs[v].exp_adr, vecs[v].exp_next, vecs[v].exp_epc);

        // reset while fetching (the cycle right after a retire)
        async_reset("rst_fetch");

        // reset at micro-cycle 2
        cur_len = 3; defined_i = 1'b1;
        iack_i = 1'b1; idat_i = 32'h0420_0093;
        @(negedge clk_i);
        iack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("pre_rst_cs2", {61'd0, cstate_o}, 64'd2);
        async_reset("rst_exec");

        // undefined instruction straight after reset
        do_instr(32'h0000_0000, 1'b0, 0, 3, 1'b0, 64'h100, TRAP, 64'h100);
        m_pc = TRAP; m_epc = 64'h100;

        for (int n = 0; n < 150; n++) begin
            logic [31:0] dat;
            bit          def;
            logic [63:0] nxt, epc;
            dat = $urandom;
            def = ($urandom_range(0, 4) != 0);
            nxt = def ? m_pc + 64'd4 : TRAP;
            epc = def ? m_epc : m_pc;
            do_instr(dat, def, $urandom_range(0, 3), $urandom_range(1, 3),
                     bit'($urandom_range(0, 1)), m_pc, nxt, epc);
            m_pc  = nxt;
            m_epc = epc;
        end

        // PC wrap on the second instance
        #2 reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("wrap_start_adr", iadr2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_start_stb", {63'd0, istb2}, 64'd1);
        iack2 = 1'b1;
        @(negedge clk_i);
        iack2 = 1'b0;
        chk("wrap_cs0", {61'd0, cstate2}, 64'd0);
        @(negedge clk_i);
        chk("wrap_cs3", {61'd0, cstate2}, 64'd3);
        @(negedge clk_i);
        chk("wrap_retire", {63'd0, retire2}, 64'd1);
        chk("wrap_adr", iadr2, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
